pe_accum_sequencer: RTL and testbench

Job-level controller for one `mul_accum` processing element. It accepts a job descriptor giving a vector count and an initial accumulator value. It streams that many 256-bit feature/filter vector pairs into the PE and tracks the PE's fixed, non-stallable pipeline latency with a tag shift register. It accumulates every returned `dot_accum` and presents the final sum on a valid/ready result port. It sits between the feature/filter buffers and the PE, and replaces the PE's constant `ovalid`/`oready` with real flow control.

---
 rtl/pe_ctrl_pkg.sv | 17 +
 rtl/pe_tag_pipe.sv | 37 +++
 rtl/pe_accum_sequencer.sv | 117 +++++++++++
 tb/tb_pe_accum_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared constants and types for the PE job controller.
package pe_ctrl_pkg;

    localparam int PE_VEC_W   = 256;
    localparam int PE_LANES   = 16;
    localparam int PE_ELEM_W  = 16;
    localparam int PE_DOT_W   = 32;
    localparam int PE_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } pe_seq_state_t;

endpackage

// File: rtl/pe_tag_pipe.sv
// LATENCY-deep tag shift register that mirrors the PE pipeline; one bit per
// in-flight beat, with the oldest beat at the output stage.
module pe_tag_pipe #(
    parameter int LATENCY = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic shift_in,
    output logic tag_out,
    output logic empty
);

    logic [LATENCY-1:0] tags_q;
    logic [LATENCY-1:0] tags_d;

    always_comb begin
        tags_d = (tags_q << 1) | LATENCY'(shift_in);
        if (clear) begin
            tags_d = '0;
        end
    end

    // Oldest tag is consumed this cycle; empty looks at what survives the edge,
    // so the controller can leave DRAIN in the same cycle as the last accumulate.
    assign tag_out = tags_q[LATENCY-1];
    assign empty   = (tags_d == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

endmodule

// File: rtl/pe_accum_sequencer.sv
// Job-level controller for one mul_accum PE: streams vector pairs in, tracks the
// fixed PE latency with a tag pipe, and accumulates results into a handshaked sum.
module pe_accum_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int LATENCY = PE_LATENCY,
    parameter int CNT_W   = 16,
    parameter int ACC_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CNT_W-1:0]     job_count,
    input  logic [ACC_W-1:0]     job_init,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PE_VEC_W-1:0]  in_feature,
    input  logic [PE_VEC_W-1:0]  in_filter,
    output logic [PE_VEC_W-1:0]  pe_feature,
    output logic [PE_VEC_W-1:0]  pe_filter,
    output logic                 pe_ivalid,
    input  logic [PE_DOT_W-1:0]  pe_dot_accum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     res_data,
    output logic                 busy
);

    pe_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             pipe_clear;
    logic             tag_out;
    logic             pipe_empty;

    assign pe_feature = in_feature;
    assign pe_filter  = in_filter;
    assign job_ready  = (state_q == ST_IDLE);
    assign in_ready   = (state_q == ST_RUN) && (remaining_q != '0);
    assign pe_ivalid  = in_valid && in_ready;
    assign res_valid  = (state_q == ST_DONE);
    assign res_data   = acc_q;
    assign busy       = (state_q != ST_IDLE);

    pe_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clock    (clock),
        .reset    (reset),
        .clear    (pipe_clear),
        .shift_in (pe_ivalid),
        .tag_out  (tag_out),
        .empty    (pipe_empty)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        pipe_clear  = 1'b0;

        // The PE cannot stall, so a returning tag is always accumulated.
        if (tag_out) begin
            acc_d = acc_q + ACC_W'($signed(pe_dot_accum));
        end

        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    remaining_d = job_count;
                    acc_d       = job_init;
                    pipe_clear  = 1'b1;
                    state_d     = (job_count == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pe_ivalid) begin
                    remaining_d = remaining_q - 1'b1;
                end
                if (remaining_d == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            pipe_clear = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_pe_accum_sequencer.sv
// Self-checking bench for pe_accum_sequencer with a latency-accurate PE model.
module tb_pe_accum_sequencer;
    import pe_ctrl_pkg::*;

    localparam int LAT = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         job_valid, job_ready;
    logic [15:0]  job_count;
    logic [31:0]  job_init;
    logic         abort;
    logic         in_valid, in_ready;
    logic [255:0] in_feature, in_filter, pe_feature, pe_filter;
    logic         pe_ivalid;
    logic [31:0]  pe_dot_accum;
    logic         res_valid, res_ready;
    logic [31:0]  res_data;
    logic         busy;

    pe_accum_sequencer #(.LATENCY(LAT), .CNT_W(16), .ACC_W(32)) dut (
        .clock(clock), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_count(job_count), .job_init(job_init), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_feature(in_feature), .in_filter(in_filter),
        .pe_feature(pe_feature), .pe_filter(pe_filter), .pe_ivalid(pe_ivalid),
        .pe_dot_accum(pe_dot_accum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // PE model: each accepted beat takes the next queued value, bubbles carry
    // random garbage, and everything emerges LAT cycles later.
    logic [31:0] ret_q[$];
    logic [31:0] dly[LAT];
    always @(posedge clock) begin
        logic [31:0] nv;
        nv = $urandom;
        if (pe_ivalid && ret_q.size() > 0) nv = ret_q.pop_front();
        dly[0] <= nv;
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign pe_dot_accum = dly[LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic start_job(input int n, input logic [31:0] init);
        job_valid = 1'b1; job_count = 16'(n); job_init = init;
        @(negedge clock);
        chk("job_ready_at_accept", job_ready, 1'b1);
        tick();
        job_valid = 1'b0;
    endtask

    // Starts in cycle T0+1; returns result and the cycle offset at which res_valid rose.
    task automatic finish_job(input int n, input int mode, output logic [31:0] res,
                              output int lat, output int last_acc);
        int acc_n;
        acc_n = 0; lat = -1; last_acc = 0; res = '0;
        for (int rel = 1; rel <= 200; rel++) begin
            if (acc_n < n) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (rel % 2 == 1);
                    default: in_valid = 1'($urandom % 2);
                endcase
            end else begin
                in_valid = 1'b0;
            end
            in_feature = {8{$urandom}};
            in_filter  = {8{$urandom}};
            @(negedge clock);
            if (res_valid) begin
                lat = rel; res = res_data;
                break;
            end
            chk("in_ready", in_ready, acc_n < n);
            chk("pe_ivalid", pe_ivalid, in_valid && (acc_n < n));
            if (in_valid && in_ready) begin
                acc_n++;
                last_acc = rel;
            end
            tick();
        end
        in_valid = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL res_valid_timeout: got none expected within 200 cycles");
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clock);
        chk("idle_job_ready", job_ready, 1'b1);
        chk("idle_res_valid", res_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_job_ready"}, job_ready, 1'b1);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_pe_ivalid"}, pe_ivalid, 1'b0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_data"}, res_data, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        int          n;
        logic [31:0] init;
        int          mode;
        logic [31:0] v[4];
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, exp, sum;
        int lat, la, n;

        tbl[0].n = 4; tbl[0].init = 32'd0;        tbl[0].mode = 0;
        tbl[0].v[0] = 10; tbl[0].v[1] = 20; tbl[0].v[2] = 30; tbl[0].v[3] = 40;
        tbl[0].exp_res = 32'd100;        tbl[0].exp_lat = 8;
        tbl[1].n = 3; tbl[1].init = 32'hFFFF_FFFB; tbl[1].mode = 1;
        tbl[1].v[0] = 32'h7FFF_FFFF; tbl[1].v[1] = 32'h7FFF_FFFF; tbl[1].v[2] = 32'h7FFF_FFFF; tbl[1].v[3] = 0;
        tbl[1].exp_res = 32'h7FFF_FFF8;  tbl[1].exp_lat = 9;
        tbl[2].n = 0; tbl[2].init = 32'h1234;     tbl[2].mode = 0;
        tbl[2].v[0] = 0; tbl[2].v[1] = 0; tbl[2].v[2] = 0; tbl[2].v[3] = 0;
        tbl[2].exp_res = 32'h1234;       tbl[2].exp_lat = 2;
        tbl[3].n = 1; tbl[3].init = 32'd100;      tbl[3].mode = 0;
        tbl[3].v[0] = 32'hFFFF_FFFF; tbl[3].v[1] = 0; tbl[3].v[2] = 0; tbl[3].v[3] = 0;
        tbl[3].exp_res = 32'd99;         tbl[3].exp_lat = 5;

        reset = 1'b1; job_valid = 1'b0; job_count = '0; job_init = '0; abort = 1'b0;
        in_valid = 1'b0; res_ready = 1'b0;
        in_feature = {8{$urandom}}; in_filter = {8{$urandom}};
        tick(); tick();
        @(negedge clock);
        chk_reset_outputs("reset");
        chk("pe_feature_pass", pe_feature[31:0], in_feature[31:0]);
        chk("pe_filter_pass", pe_filter[255:224], in_filter[255:224]);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            ret_q.delete();
            for (int i = 0; i < tbl[k].n; i++) ret_q.push_back(tbl[k].v[i]);
            start_job(tbl[k].n, tbl[k].init);
            finish_job(tbl[k].n, tbl[k].mode, res, lat, la);
            chk($sformatf("tbl%0d_res", k), res, tbl[k].exp_res);
            chk($sformatf("tbl%0d_lat", k), lat, tbl[k].exp_lat);
            handshake();
        end

        // Result held in DONE while job_valid waits; next job only after handshake.
        ret_q.delete(); ret_q.push_back(1); ret_q.push_back(2);
        start_job(2, 0);
        finish_job(2, 0, res, lat, la);
        chk("hold_res", res, 32'd3);
        chk("hold_lat", lat, 6);
        job_valid = 1'b1; job_count = 16'd1; job_init = 32'd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clock);
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_data", res_data, 32'd3);
            chk("hold_job_ready", job_ready, 1'b0);
        end
        ret_q.delete(); ret_q.push_back(5);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clock);
        chk("b2b_job_ready", job_ready, 1'b1);
        chk("b2b_busy", busy, 1'b0);
        tick();
        job_valid = 1'b0;
        finish_job(1, 0, res, lat, la);
        chk("b2b_res", res, 32'd55);
        chk("b2b_lat", lat, 5);
        handshake();

        // Abort in DRAIN with two tags in flight, then a fresh job right away.
        ret_q.delete(); ret_q.push_back(111); ret_q.push_back(222);
        start_job(2, 0);
        in_valid = 1'b1; tick(); tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("drain_busy", busy, 1'b1);
        chk("drain_res_valid", res_valid, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        chk_reset_outputs("abort");
        tick();
        ret_q.delete(); ret_q.push_back(7);
        start_job(1, 0);
        finish_job(1, 0, res, lat, la);
        chk("post_abort_res", res, 32'd7);
        handshake();

        // abort wins over a job offered in the same IDLE cycle.
        job_valid = 1'b1; job_count = 16'd2; abort = 1'b1;
        tick();
        job_valid = 1'b0; abort = 1'b0;
        @(negedge clock);
        chk("abort_override_busy", busy, 1'b0);
        tick();

        // Reset mid-RUN with beats in flight.
        ret_q.delete();
        for (int i = 0; i < 4; i++) ret_q.push_back(32'h1000 + i);
        start_job(4, 0);
        in_valid = 1'b1; tick(); tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk_reset_outputs("midrun_reset");
        reset = 1'b0; in_valid = 1'b0;
        tick();
        ret_q.delete(); ret_q.push_back(9);
        start_job(1, 3);
        finish_job(1, 0, res, lat, la);
        chk("post_reset_res", res, 32'd12);
        chk("post_reset_lat", lat, 5);
        handshake();

        // Random jobs against the arithmetic reference: init plus sum of returned values.
        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(0, 10);
            exp = $urandom;
            sum = exp;
            ret_q.delete();
            for (int i = 0; i < n; i++) begin
                logic [31:0] v;
                v = $urandom;
                ret_q.push_back(v);
                sum = sum + v;
            end
            start_job(n, exp);
            finish_job(n, 2, res, lat, la);
            chk($sformatf("rand%0d_res", j), res, sum);
            chk($sformatf("rand%0d_lat", j), lat, (n == 0) ? 2 : la + LAT + 1);
            handshake();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
